// File: rtl/debug_frame_rx_pkg.sv
// Shared debugger-link definitions: receive FSM state encodings and frame/timeout defaults.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package debug_frame_rx_pkg;

    // Default frame size in bytes (frame width = 8 * DEF_NUM_BYTES bits).
    localparam int DEF_NUM_BYTES = 220;

    // Inter-byte gap limit in clock cycles; the transmitter uses the same value.
    localparam int DEF_TIMEOUT = 50000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SETTLE  = 2'd2,
        FULL    = 2'd3
    } rx_state_t;

endpackage

// File: rtl/debug_frame_rx_inter_byte_timer.sv
// Inter-byte gap counter: counts enabled cycles and flags when TIMEOUT of them have elapsed.
// Latency: expire is combinational in the cycle that completes the TIMEOUT-th enabled count.
// Backpressure: none; clear and enable are sampled every cycle.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-low reset
//   clear          force the count back to zero (takes priority over enable)
//   enable         count this cycle
//   expire         high on the TIMEOUT-th consecutive enabled cycle
module debug_frame_rx_inter_byte_timer
    import debug_frame_rx_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TO_W    = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TO_W-1:0] count;

    // count holds the number of enabled cycles already completed, so the
    // TIMEOUT-th enabled cycle is the one that sees TIMEOUT-1.
    assign expire = enable && (count == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TO_W'(1);
        end
    end

endmodule

// File: rtl/debug_frame_rx.sv
// Reassembles NUM_BYTES UART bytes into one wide frame, presented with a valid/ack handshake.
// Latency: frame_valid rises 2 cycles after the last byte's rd_uart pulse; at most one byte per 2 cycles.
// Backpressure: while a frame waits for frame_ack no bytes are read, they stay buffered in the UART.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-low reset
//   r_data         byte from the UART receive buffer
//   rx_ready       UART holds an unread byte (dropped by the UART the cycle after rd_uart)
//   rd_uart        one-cycle pulse: r_data consumed this cycle
//   frame_data     assembled frame, first received byte in [7:0]
//   frame_valid    frame_data complete and stable until frame_ack
//   frame_ack      consumer accepts the frame (only honoured while frame_valid=1)
//   frame_error    one-cycle pulse: partial frame abandoned after an inter-byte timeout
//   byte_count     bytes captured into the current frame
module debug_frame_rx
    import debug_frame_rx_pkg::*;
#(
    parameter int NUM_BYTES = DEF_NUM_BYTES,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int TO_W      = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             r_data,
    input  logic                   rx_ready,
    output logic                   rd_uart,
    output logic [8*NUM_BYTES-1:0] frame_data,
    output logic                   frame_valid,
    input  logic                   frame_ack,
    output logic                   frame_error,
    output logic [CNT_W-1:0]       byte_count
);

    rx_state_t state, state_n;

    logic take;        // capture r_data into lane byte_count this cycle
    logic count_clr;   // drop back to an empty frame
    logic valid_set;
    logic valid_clr;
    logic error_n;
    logic timer_clr;
    logic timer_en;
    logic timer_expire;

    // Idle cycles are only counted while a partial frame is waiting for its next byte.
    assign timer_en  = (state == CAPTURE) && !rx_ready;
    assign timer_clr = (state != CAPTURE) || take;

    debug_frame_rx_inter_byte_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clr),
        .enable (timer_en),
        .expire (timer_expire)
    );

    always_comb begin
        state_n   = state;
        take      = 1'b0;
        count_clr = 1'b0;
        valid_set = 1'b0;
        valid_clr = 1'b0;
        error_n   = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so no byte is acknowledged to the UART while held in reset.
                if (rx_ready && reset) begin
                    take    = 1'b1;
                    state_n = SETTLE;
                end
            end
            CAPTURE: begin
                if (rx_ready) begin
                    take    = 1'b1;
                    state_n = SETTLE;
                end else if (timer_expire) begin
                    error_n   = 1'b1;
                    count_clr = 1'b1;
                    state_n   = IDLE;
                end
            end
            SETTLE: begin
                // rx_ready is still high from the byte just read; ignore it for one cycle.
                if (byte_count == CNT_W'(NUM_BYTES)) begin
                    valid_set = 1'b1;
                    state_n   = FULL;
                end else begin
                    state_n = CAPTURE;
                end
            end
            FULL: begin
                if (frame_ack) begin
                    valid_clr = 1'b1;
                    count_clr = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rd_uart = take;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            byte_count  <= '0;
        end else begin
            state       <= state_n;
            frame_error <= error_n;
            if (take) begin
                // In IDLE byte_count is 0, so lane 0 is written without a special case.
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (byte_count == CNT_W'(i)) begin
                        frame_data[i*8 +: 8] <= r_data;
                    end
                end
                byte_count <= byte_count + CNT_W'(1);
            end else if (count_clr) begin
                byte_count <= '0;
            end
            if (valid_set) begin
                frame_valid <= 1'b1;
            end else if (valid_clr) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debug_frame_rx.sv
module tb_debug_frame_rx;

    localparam int NB = 4;
    localparam int CW = 8;
    localparam int TO = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    r_data = 8'h00;
    logic          rx_ready = 1'b0;
    logic          rd_uart;
    logic [8*NB-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ack = 1'b0;
    logic          frame_error;
    logic [CW-1:0] byte_count;

    debug_frame_rx #(
        .NUM_BYTES (NB),
        .CNT_W     (CW),
        .TIMEOUT   (TO),
        .TO_W      (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .r_data      (r_data),
        .rx_ready    (rx_ready),
        .rd_uart     (rd_uart),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_error (frame_error),
        .byte_count  (byte_count)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    int err_cnt  = 0;
    int rd_cyc   = 0;
    int err_cyc  = 0;

    always @(posedge clock) cyc++;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (rd_uart) begin
            rd_cnt++;
            rd_cyc = cyc;
        end
        if (frame_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    typedef struct {
        logic [31:0] bytes;     // byte j sent is bytes[8j+:8]
        int          gap;       // idle cycles inserted between bytes
        logic [31:0] exp_data;
    } vec_t;

    vec_t tv [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // UART model: present a byte, wait for rd_uart, drop rx_ready the cycle after.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        r_data   = b;
        rx_ready = 1'b1;
        @(negedge clock);
        while (!rd_uart && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!rd_uart) begin
            checks++;
            failures++;
            $display("FAIL send_byte_wait actual=no_rd_uart expected=rd_uart byte=%h", b);
        end
        @(posedge clock);
        #1 rx_ready = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clock);
        while (!frame_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!frame_valid) begin
            checks++;
            failures++;
            $display("FAIL wait_valid actual=0 expected=1");
        end
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        @(posedge clock);
        #1 frame_ack = 1'b0;
    endtask

    initial begin
        int rd0, e0, prev;
        logic [31:0] held;
        logic [7:0] b2b [4];

        tv[0] = '{32'h44332211, 5,  32'h44332211};
        tv[1] = '{32'hEFBEADDE, 0,  32'hEFBEADDE};
        tv[2] = '{32'hA55AFF00, 1,  32'hA55AFF00};
        tv[3] = '{32'hFE7F8001, 3,  32'hFE7F8001};
        tv[4] = '{32'h693C96C3, 20, 32'h693C96C3}; // 19 idle CAPTURE cycles: just under timeout

        // Reset values
        #2;
        check("rst_rd_uart", 32'(rd_uart), 32'd0);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        check("rst_frame_data", frame_data, 32'h0);
        #21 reset = 1'b1;
        idle(2);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            rd0 = rd_cnt;
            e0  = err_cnt;
            for (int j = 0; j < NB; j++) begin
                send_byte(tv[i].bytes[j*8 +: 8]);
                if (j < NB - 1) idle(tv[i].gap);
            end
            wait_valid();
            check($sformatf("v%0d_latency", i), 32'(cyc - rd_cyc), 32'd2);
            check($sformatf("v%0d_frame_data", i), frame_data, tv[i].exp_data);
            check($sformatf("v%0d_byte_count", i), 32'(byte_count), 32'd4);
            check($sformatf("v%0d_rd_pulses", i), 32'(rd_cnt - rd0), 32'd4);
            check($sformatf("v%0d_no_error", i), 32'(err_cnt - e0), 32'd0);
            @(posedge clock); #1;
            pulse_ack();
            @(negedge clock);
            check($sformatf("v%0d_valid_after_ack", i), 32'(frame_valid), 32'd0);
            check($sformatf("v%0d_count_after_ack", i), 32'(byte_count), 32'd0);
            @(posedge clock); #1;
        end

        // Back-to-back: rx_ready held high, new byte after each consumption
        b2b[0] = 8'h12; b2b[1] = 8'h34; b2b[2] = 8'h56; b2b[3] = 8'h78;
        rd0 = rd_cnt;
        prev = 0;
        rx_ready = 1'b1;
        r_data   = b2b[0];
        for (int k = 0; k < NB; k++) begin
            int n;
            n = 0;
            @(negedge clock);
            while (!rd_uart && n < 10) begin
                @(negedge clock);
                n++;
            end
            check($sformatf("b2b_rd_%0d", k), 32'(rd_uart), 32'd1);
            if (k > 0) check($sformatf("b2b_spacing_%0d", k), 32'(cyc - prev), 32'd2);
            prev = cyc;
            @(posedge clock); #1;
            if (k < NB - 1) r_data = b2b[k+1];
        end
        rx_ready = 1'b0;
        wait_valid();
        check("b2b_frame_data", frame_data, 32'h78563412);
        check("b2b_rd_pulses", 32'(rd_cnt - rd0), 32'd4);
        @(posedge clock); #1;
        pulse_ack();

        // Timeout: 2 bytes then silence. rd_uart cycle, SETTLE, then 20 idle
        // CAPTURE cycles; the error pulse appears in the cycle after the 20th.
        e0 = err_cnt;
        send_byte(8'h01);
        send_byte(8'h02);
        idle(25);
        check("to_error_pulses", 32'(err_cnt - e0), 32'd1);
        check("to_error_timing", 32'(err_cyc - rd_cyc), 32'd22);
        check("to_byte_count", 32'(byte_count), 32'd0);
        check("to_frame_valid", 32'(frame_valid), 32'd0);
        for (int j = 0; j < NB; j++) send_byte(8'hA0 + 8'(j));
        wait_valid();
        check("to_refill_data", frame_data, 32'hA3A2A1A0);
        check("to_no_extra_error", 32'(err_cnt - e0), 32'd1);

        // Hold: frame waiting, byte 0x55 pending, no ack for 30 cycles
        @(posedge clock); #1;
        held = frame_data;
        rd0  = rd_cnt;
        e0   = err_cnt;
        r_data   = 8'h55;
        rx_ready = 1'b1;
        idle(30);
        check("hold_no_rd", 32'(rd_cnt - rd0), 32'd0);
        check("hold_no_error", 32'(err_cnt - e0), 32'd0);
        check("hold_data_stable", frame_data, held);
        check("hold_valid", 32'(frame_valid), 32'd1);
        pulse_ack();
        @(negedge clock);
        check("hold_valid_fall", 32'(frame_valid), 32'd0);
        check("hold_take_55", 32'(rd_uart), 32'd1);
        @(posedge clock);
        #1 rx_ready = 1'b0;
        check("hold_lane0", 32'(frame_data[7:0]), 32'h55);
        check("hold_count1", 32'(byte_count), 32'd1);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        wait_valid();
        check("hold_frame", frame_data, 32'h88776655);
        @(posedge clock); #1;
        pulse_ack();

        // Async reset after 3 bytes, asserted away from any edge
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        #2 reset = 1'b0;
        #1;
        check("arst_byte_count", 32'(byte_count), 32'd0);
        check("arst_frame_data", frame_data, 32'h0);
        check("arst_frame_valid", 32'(frame_valid), 32'd0);
        check("arst_frame_error", 32'(frame_error), 32'd0);
        r_data   = 8'h9A;
        rx_ready = 1'b1;
        #1;
        check("arst_rd_gated", 32'(rd_uart), 32'd0);
        @(posedge clock);
        #3 reset = 1'b1;
        @(negedge clock);
        check("arst_pending_taken", 32'(rd_uart), 32'd1);
        @(posedge clock);
        #1 rx_ready = 1'b0;
        send_byte(8'hBC);
        send_byte(8'hDE);
        send_byte(8'hF0);
        wait_valid();
        check("arst_clean_frame", frame_data, 32'hF0DEBC9A);
        @(posedge clock); #1;
        pulse_ack();

        // frame_ack outside FULL is ignored
        pulse_ack();
        @(negedge clock);
        check("ack_idle_count", 32'(byte_count), 32'd0);
        check("ack_idle_valid", 32'(frame_valid), 32'd0);
        @(posedge clock); #1;
        send_byte(8'h0A);
        idle(3);
        pulse_ack();
        @(negedge clock);
        check("ack_capture_count", 32'(byte_count), 32'd1);
        check("ack_capture_valid", 32'(frame_valid), 32'd0);
        @(posedge clock); #1;
        send_byte(8'h0B);
        send_byte(8'h0C);
        send_byte(8'h0D);
        wait_valid();
        check("ack_capture_frame", frame_data, 32'h0D0C0B0A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
